// File: rtl/cd_param_pkg.sv
// ---------------------------------------------------------------------------
// cd_param_pkg
// Shared definitions for the parametrised single-cycle datapath:
//   - ALU operation encodings
//   - instruction field bit positions
//   - width helper for the return-stack occupancy counter
// ---------------------------------------------------------------------------
package cd_param_pkg;

  // ALU operation encodings (op_alu)
  localparam logic [2:0] ALU_A    = 3'b000;
  localparam logic [2:0] ALU_NOTA = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_OR   = 3'b101;
  localparam logic [2:0] ALU_NEGA = 3'b110;
  localparam logic [2:0] ALU_NEGB = 3'b111;

  // Instruction field bit positions
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 10;
  localparam int RA1_MSB = 11;
  localparam int RA1_LSB = 8;
  localparam int RA2_MSB = 7;
  localparam int RA2_LSB = 4;
  localparam int WA3_MSB = 3;
  localparam int WA3_LSB = 0;
  localparam int INM_MSB = 11;
  localparam int INM_LSB = 4;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int sp_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/cd_param_pc_stack.sv
// ---------------------------------------------------------------------------
// pc_stack
// Return-address LIFO used for subroutine call/return.
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-low reset (clears count and error flags)
//   push      in   push din (ignored when full -> err_over)
//   pop       in   pop top (ignored when empty -> err_under); wins over push
//   din       in   address to push
//   top       out  current top-of-stack entry
//   count     out  occupancy 0..STACK_DEPTH
//   full      out  count == STACK_DEPTH
//   empty     out  count == 0
//   err_over  out  sticky: push attempted while full
//   err_under out  sticky: pop attempted while empty
// Storage contents are not reset; only the occupancy is meaningful.
// ---------------------------------------------------------------------------
module pc_stack
  import cd_param_pkg::*;
#(
  parameter int PC_W        = 10,
  parameter int STACK_DEPTH = 4,
  localparam int SP_W       = sp_width(STACK_DEPTH),
  localparam int IDX_W      = $clog2(STACK_DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] din,
  output logic [PC_W-1:0] top,
  output logic [SP_W-1:0] count,
  output logic            full,
  output logic            empty,
  output logic            err_over,
  output logic            err_under
);

  logic [PC_W-1:0]  mem_q [0:STACK_DEPTH-1];
  logic [SP_W-1:0]  count_q, count_d;
  logic             err_over_q, err_over_d;
  logic             err_under_q, err_under_d;
  logic             mem_we;
  logic [IDX_W-1:0] top_idx;
  logic [IDX_W-1:0] wr_idx;

  assign full  = (count_q == SP_W'(STACK_DEPTH));
  assign empty = (count_q == '0);

  // Top entry sits one below the occupancy count; when empty the value is
  // a don't-care that the caller never uses.
  assign top_idx = IDX_W'(count_q - SP_W'(1));
  assign wr_idx  = IDX_W'(count_q);
  assign top     = mem_q[top_idx];

  always_comb begin
    count_d     = count_q;
    err_over_d  = err_over_q;
    err_under_d = err_under_q;
    mem_we      = 1'b0;
    if (pop) begin
      if (!empty) count_d = count_q - SP_W'(1);
      else        err_under_d = 1'b1;
    end else if (push) begin
      if (!full) begin
        count_d = count_q + SP_W'(1);
        mem_we  = 1'b1;
      end else begin
        // Return address is dropped; the jump itself still happens upstream.
        err_over_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q     <= '0;
      err_over_q  <= 1'b0;
      err_under_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      err_over_q  <= err_over_d;
      err_under_q <= err_under_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_idx] <= din;
  end

  assign count     = count_q;
  assign err_over  = err_over_q;
  assign err_under = err_under_q;

endmodule

// File: rtl/cd_param.sv
// ---------------------------------------------------------------------------
// cd_param
// Parametrised single-cycle datapath with a hardware return-address stack,
// registered zero/carry flags, a pipeline-hold enable and sticky stack
// error flags. Program memory is external: pc is driven out and instr comes
// back combinationally.
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-low reset
//   en        in   1 = execute this cycle, 0 = hold all state
//   instr     in   instruction word at address pc
//   s_inc     in   1 = pc+1, 0 = jump to instr[PC_W-1:0]
//   s_inm     in   1 = write immediate instr[11:4], 0 = write ALU result
//   we3       in   register-file write enable
//   wez       in   z/c flag update enable
//   s_call    in   push pc+1 and jump to target
//   s_ret     in   pop return address into pc (wins over s_call)
//   op_alu    in   ALU operation
//   pc        out  current PC
//   opcode    out  instr[15:10]
//   z, c      out  registered zero / carry flags
//   sp        out  return-stack occupancy
//   err_over  out  sticky push-when-full
//   err_under out  sticky pop-when-empty
// ---------------------------------------------------------------------------
module cd_param
  import cd_param_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int PC_W        = 10,
  parameter int STACK_DEPTH = 4,
  localparam int SP_W       = sp_width(STACK_DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [15:0]     instr,
  input  logic            s_inc,
  input  logic            s_inm,
  input  logic            we3,
  input  logic            wez,
  input  logic            s_call,
  input  logic            s_ret,
  input  logic [2:0]      op_alu,
  output logic [PC_W-1:0] pc,
  output logic [5:0]      opcode,
  output logic            z,
  output logic            c,
  output logic [SP_W-1:0] sp,
  output logic            err_over,
  output logic            err_under
);

  // ------------------------------------------------------------ fields
  logic [3:0]        wa3, ra2, ra1;
  logic [DATA_W-1:0] inm;
  logic [PC_W-1:0]   target;

  assign opcode = instr[OPC_MSB:OPC_LSB];
  assign wa3    = instr[WA3_MSB:WA3_LSB];
  assign ra2    = instr[RA2_MSB:RA2_LSB];
  assign ra1    = instr[RA1_MSB:RA1_LSB];
  assign inm    = DATA_W'(instr[INM_MSB:INM_LSB]);
  assign target = instr[PC_W-1:0];

  // ------------------------------------------------------------ register file
  logic [DATA_W-1:0] rf_q [0:15];
  logic [DATA_W-1:0] rd1, rd2, wd3;

  // r0 is hard-wired to zero on read; writes to it are dropped.
  assign rd1 = (ra1 == 4'd0) ? '0 : rf_q[ra1];
  assign rd2 = (ra2 == 4'd0) ? '0 : rf_q[ra2];

  always_ff @(posedge clk) begin
    if (en && we3 && (wa3 != 4'd0)) rf_q[wa3] <= wd3;
  end

  // ------------------------------------------------------------ ALU
  logic [DATA_W:0]   add_w, sub_w;
  logic [DATA_W-1:0] alu_res;
  logic              alu_cy;

  // Subtraction is formed as A + ~B + 1 so its carry-out is the
  // "no borrow" indication (set when A >= B).
  assign add_w = {1'b0, rd1} + {1'b0, rd2};
  assign sub_w = {1'b0, rd1} + {1'b0, ~rd2} + {{DATA_W{1'b0}}, 1'b1};

  always_comb begin
    alu_res = rd1;
    alu_cy  = 1'b0;
    case (op_alu)
      ALU_A:    alu_res = rd1;
      ALU_NOTA: alu_res = ~rd1;
      ALU_ADD:  {alu_cy, alu_res} = add_w;
      ALU_SUB:  {alu_cy, alu_res} = sub_w;
      ALU_AND:  alu_res = rd1 & rd2;
      ALU_OR:   alu_res = rd1 | rd2;
      ALU_NEGA: alu_res = '0 - rd1;
      ALU_NEGB: alu_res = '0 - rd2;
      default:  alu_res = rd1;
    endcase
  end

  assign wd3 = s_inm ? inm : alu_res;

  // ------------------------------------------------------------ flags
  logic z_q, z_d, c_q, c_d;

  always_comb begin
    z_d = z_q;
    c_d = c_q;
    if (en && wez) begin
      z_d = (alu_res == '0);
      c_d = alu_cy;
    end
  end

  // ------------------------------------------------------------ return stack
  logic [PC_W-1:0] pc_q, pc_d, pc_plus1, stk_top;
  logic            stk_push, stk_pop, stk_full, stk_empty;
  logic [SP_W-1:0] stk_count;

  // Natural PC_W-bit wrap gives (2^PC_W-1) -> 0 for both pc+1 and the
  // pushed return address.
  assign pc_plus1 = pc_q + PC_W'(1);

  // s_ret dominates s_call, so a simultaneous request only pops.
  assign stk_pop  = en & s_ret;
  assign stk_push = en & s_call & ~s_ret;

  pc_stack #(
    .PC_W       (PC_W),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_stack (
    .clk      (clk),
    .reset    (reset),
    .push     (stk_push),
    .pop      (stk_pop),
    .din      (pc_plus1),
    .top      (stk_top),
    .count    (stk_count),
    .full     (stk_full),
    .empty    (stk_empty),
    .err_over (err_over),
    .err_under(err_under)
  );

  // ------------------------------------------------------------ next PC
  always_comb begin
    pc_d = pc_q;
    if (en) begin
      if (s_ret)       pc_d = stk_empty ? pc_plus1 : stk_top;
      else if (s_call) pc_d = target;   // jump even when the push overflows
      else if (s_inc)  pc_d = pc_plus1;
      else             pc_d = target;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= '0;
      z_q  <= 1'b0;
      c_q  <= 1'b0;
    end else begin
      pc_q <= pc_d;
      z_q  <= z_d;
      c_q  <= c_d;
    end
  end

  // stk_full is exposed for completeness of the stack interface; the
  // overflow decision itself lives inside pc_stack.
  logic unused_full;
  assign unused_full = stk_full;

  assign pc = pc_q;
  assign z  = z_q;
  assign c  = c_q;
  assign sp = stk_count;

endmodule
